pc_stack: RTL

- Parametrised program counter; next generation of the 16-bit counter-based PC.
- Address width is generic (multiple of 8). The high-address staging register is loaded one byte at a time from the 8-bit data bus.
- Adds a count-enable and a hardware return-address stack with call and return, plus sticky overflow/underflow flags.
- Sits between the control decoder and the program ROM address bus; the data bus D is shared with the ALU result bus.

---
 rtl/pc_stack_if.sv | 31 +++
 rtl/pc_stack.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// Control/data bundle between the decoder side and the program counter.
// Inputs are active-low strobes except CE; outputs are all registered.
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int SW = $clog2(DEPTH + 1);

    logic             _pchitmp_in;
    logic             _pclo_in;
    logic             _pc_in;
    logic             _call;
    logic             _ret;
    logic             CE;
    logic [7:0]       D;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-9:0] HITMP;
    logic [SW-1:0]    SP;
    logic             OVF;
    logic             UNF;

    modport master (
        output _pchitmp_in, _pclo_in, _pc_in, _call, _ret, CE, D,
        input  PC, HITMP, SP, OVF, UNF
    );

    modport slave (
        input  _pchitmp_in, _pclo_in, _pc_in, _call, _ret, CE, D,
        output PC, HITMP, SP, OVF, UNF
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with byte-staged jumps, count enable and a
// return-address stack (oldest entry is dropped on overflow).
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LOG   = 0
) (
    input logic       clk,
    input logic       MR,
    pc_stack_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SW-1:0] FULL = SW'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-9:0] hitmp;
    logic [WIDTH-9:0] hitmp_nxt;
    logic [SW-1:0]    sp;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] stk [DEPTH];

    logic             push;
    logic             pop;
    logic             unf_set;
    logic             full;
    logic             empty;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    wr_idx;

    assign full    = (sp == FULL);
    assign empty   = (sp == '0);
    assign top_idx = IW'(sp - SW'(1));
    assign wr_idx  = IW'(sp);
    assign pc_inc  = pc + WIDTH'(1);
    assign tgt     = {hitmp, bus.D};

    // Wider PCs shift bytes in MSB-first; 16-bit holds a single byte.
    generate
        if (WIDTH > 16) begin : g_wide
            assign hitmp_nxt = {hitmp[WIDTH-17:0], bus.D};
        end else begin : g_narrow
            assign hitmp_nxt = bus.D;
        end
    endgenerate

    always_comb begin
        pc_nxt  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        unf_set = 1'b0;
        if (!bus._pc_in) begin
            pc_nxt = tgt;
            push   = !bus._call;
        end else if (!bus._pclo_in) begin
            pc_nxt = {pc[WIDTH-1:8], bus.D};
        end else if (!bus._ret) begin
            if (!empty) begin
                pc_nxt = stk[top_idx];
                pop    = 1'b1;
            end else begin
                unf_set = 1'b1;
                if (bus.CE) pc_nxt = pc_inc;
            end
        end else if (bus.CE) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            pc    <= '0;
            hitmp <= '0;
            sp    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (!bus._pchitmp_in) hitmp <= hitmp_nxt;
            if (push && !full) sp <= sp + SW'(1);
            else if (pop) sp <= sp - SW'(1);
            if (push && full) ovf <= 1'b1;
            if (unf_set) unf <= 1'b1;
        end
    end

    // Full push shifts everything down one slot, losing entry 0.
    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= pc_inc;
            end else begin
                stk[wr_idx] <= pc_inc;
            end
        end
    end

    assign bus.PC    = pc;
    assign bus.HITMP = hitmp;
    assign bus.SP    = sp;
    assign bus.OVF   = ovf;
    assign bus.UNF   = unf;
endmodule
